// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential controller that issues one opcode and two 8-bit
// operands to the combinational arithmetic cells. It waits a settle time and
// captures the selected cell result. The result is returned on a valid/ready
// response channel.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_op/req_a/req_b            opcode, operands
//   req_use_acc                   use the accumulator as operand A (optional feature)
//   rsp_valid/rsp_ready           response handshake
//   rsp_data/rsp_err/rsp_op       result, divide-by-zero flag, opcode echo
//   busy                          controller not idle
//   alu_a/alu_b/alu_cmp_cmd       registered drive to the cells
//   alu_sum/minus/mul/quot/rem/flag  cell results
//
// Optional feature: define ALU_ISSUE_ACC_EN to add an 8-bit accumulator.
// An accepted request with req_use_acc=1 then takes operand A from it.
// Non-error ops 0-4 reload it from the low byte of their result.
module alu_issue_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic        req_use_acc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [2:0]  rsp_op,
    output logic        busy,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [1:0]  alu_cmp_cmd,
    input  logic [7:0]  alu_sum,
    input  logic [7:0]  alu_minus,
    input  logic [15:0] alu_mul,
    input  logic [7:0]  alu_quot,
    input  logic [7:0]  alu_rem,
    input  logic        alu_flag
);

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               req_ready_d, rsp_valid_d, rsp_err_d, busy_d;
    logic [15:0]        rsp_data_d;
    logic [2:0]         rsp_op_d;
    logic [7:0]         alu_a_d, alu_b_d;
    logic [1:0]         alu_cmp_cmd_d;
    logic [7:0]         acc, acc_d;
    logic [7:0]         a_src;

`ifdef ALU_ISSUE_ACC_EN
    assign a_src = req_use_acc ? acc : req_a;
`else
    logic unused_use_acc;
    assign unused_use_acc = req_use_acc;
    assign a_src          = req_a;
`endif

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_op      <= '0;
            busy        <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_cmp_cmd <= 2'b00;
            acc         <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            op_q        <= op_d;
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data    <= rsp_data_d;
            rsp_err     <= rsp_err_d;
            rsp_op      <= rsp_op_d;
            busy        <= busy_d;
            alu_a       <= alu_a_d;
            alu_b       <= alu_b_d;
            alu_cmp_cmd <= alu_cmp_cmd_d;
            acc         <= acc_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        op_d          = op_q;
        req_ready_d   = req_ready;
        rsp_valid_d   = rsp_valid;
        rsp_data_d    = rsp_data;
        rsp_err_d     = rsp_err;
        rsp_op_d      = rsp_op;
        alu_a_d       = alu_a;
        alu_b_d       = alu_b;
        alu_cmp_cmd_d = alu_cmp_cmd;
        acc_d         = acc;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    alu_a_d     = a_src;
                    alu_b_d     = req_b;
                    op_d        = req_op;
                    cnt_d       = CNT_W'(SETTLE_EFF - 1);
                    req_ready_d = 1'b0;
                    state_d     = ISSUE;
                    case (req_op)
                        3'd6:    alu_cmp_cmd_d = 2'b01;
                        3'd7:    alu_cmp_cmd_d = 2'b10;
                        default: alu_cmp_cmd_d = 2'b00;
                    endcase
                end
            end
            ISSUE: begin
                if (cnt == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_op_d    = op_q;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                    case (op_q)
                        3'd0:    rsp_data_d = {8'h00, alu_sum};
                        3'd1:    rsp_data_d = {8'h00, alu_minus};
                        3'd2:    rsp_data_d = alu_mul;
                        3'd3:    rsp_data_d = {8'h00, alu_quot};
                        3'd4:    rsp_data_d = {8'h00, alu_rem};
                        default: rsp_data_d = {15'b0, alu_flag};
                    endcase
                    // Division by zero overrides whatever the cell produced
                    if ((op_q == 3'd3 || op_q == 3'd4) && alu_b == '0) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end
`ifdef ALU_ISSUE_ACC_EN
                    if (op_q <= 3'd4 && !rsp_err_d) begin
                        acc_d = rsp_data_d[7:0];
                    end
`endif
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized and directed bench for alu_issue_ctrl with scoreboard checking.
// The arithmetic cells are modelled behaviourally here.
module tb_alu_issue_ctrl;

    localparam int unsigned SETTLE = 4;
`ifdef ALU_ISSUE_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_use_acc;
    logic [2:0]  req_op;
    logic [7:0]  req_a, req_b;
    logic        rsp_valid, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_op;
    logic        busy;
    logic [7:0]  alu_a, alu_b, alu_sum, alu_minus, alu_quot, alu_rem;
    logic [15:0] alu_mul;
    logic [1:0]  alu_cmp_cmd;
    logic        alu_flag;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit hold   = 1'b0;
    logic [7:0] m_acc;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] data;
        logic        err;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  cmd;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   have_cur = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_op(rsp_op), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmp_cmd(alu_cmp_cmd),
        .alu_sum(alu_sum), .alu_minus(alu_minus), .alu_mul(alu_mul),
        .alu_quot(alu_quot), .alu_rem(alu_rem), .alu_flag(alu_flag)
    );

    // Behavioural arithmetic cells; divide by zero returns junk on purpose
    assign alu_sum   = alu_a + alu_b;
    assign alu_minus = alu_a - alu_b;
    assign alu_mul   = 16'(alu_a) * 16'(alu_b);
    assign alu_quot  = (alu_b == 8'd0) ? 8'hFF : alu_a / alu_b;
    assign alu_rem   = (alu_b == 8'd0) ? alu_a : alu_a % alu_b;
    assign alu_flag  = (alu_cmp_cmd == 2'b00) ? (alu_a == alu_b) :
                       (alu_cmp_cmd == 2'b01) ? (alu_a >  alu_b) :
                       (alu_cmp_cmd == 2'b10) ? (alu_a <  alu_b) : 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference result from plain integer arithmetic
    function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [15:0] d, output logic e);
        int ia = int'(a);
        int ib = int'(b);
        e = 1'b0;
        d = 16'd0;
        case (op)
            3'd0: d = 16'((ia + ib) % 256);
            3'd1: d = 16'((ia - ib + 256) % 256);
            3'd2: d = 16'(ia * ib);
            3'd3: if (ib == 0) e = 1'b1; else d = 16'(ia / ib);
            3'd4: if (ib == 0) e = 1'b1; else d = 16'(ia % ib);
            3'd5: d = (ia == ib) ? 16'd1 : 16'd0;
            3'd6: d = (ia >  ib) ? 16'd1 : 16'd0;
            default: d = (ia < ib) ? 16'd1 : 16'd0;
        endcase
    endfunction

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic use_acc);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_use_acc = use_acc;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fail_now("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        e.a = (ACC_EN && use_acc) ? m_acc : a;
        e.b = b;
        model(op, e.a, b, e.data, e.err);
        if (ACC_EN && op <= 3'd4 && !e.err) m_acc = e.data[7:0];
        e.op      = op;
        e.cmd     = (op == 3'd6) ? 2'b01 : (op == 3'd7) ? 2'b10 : 2'b00;
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        // Junk on the request bus while busy must be ignored
        req_valid = 1'b0;
        req_op = 3'($urandom); req_a = 8'($urandom); req_b = 8'($urandom); req_use_acc = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || have_cur || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || have_cur || busy) fail_now("idle_timeout");
    endtask

    // Consumer: random backpressure unless a hold is requested
    always @(posedge clk) begin
        #1;
        rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: pop expected entry on each new response, then check stability
    always @(negedge clk) begin
        if (rst) begin
            have_cur = 1'b0;
        end else if (rsp_valid) begin
            chk("ready_excl", 32'(req_ready), 32'd0);
            if (!have_cur) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                    chk("rsp_data", 32'(rsp_data), 32'(cur.data));
                    chk("rsp_err", 32'(rsp_err), 32'(cur.err));
                    chk("rsp_op", 32'(rsp_op), 32'(cur.op));
                    chk("latency", 32'(cyc - cur.acc_cyc), 32'(SETTLE));
                    chk("alu_a", 32'(alu_a), 32'(cur.a));
                    chk("alu_b", 32'(alu_b), 32'(cur.b));
                    chk("alu_cmp_cmd", 32'(alu_cmp_cmd), 32'(cur.cmd));
                    chk("busy", 32'(busy), 32'd1);
                end
            end else begin
                chk("hold_data", 32'(rsp_data), 32'(cur.data));
                chk("hold_err", 32'(rsp_err), 32'(cur.err));
                chk("hold_op", 32'(rsp_op), 32'(cur.op));
            end
            if (rsp_ready) have_cur = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_use_acc = 1'b0;
        m_acc = 8'h00;
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_op", 32'(rsp_op), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_cmd", 32'(alu_cmp_cmd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        send(3'd0, 8'hF0, 8'h20, 1'b0);
        wait_idle();
        chk("add_wrap", 32'(rsp_data), 32'h0010);

        // Backpressure: response must hold for five cycles
        hold = 1'b1;
        send(3'd2, 8'hFF, 8'hFF, 1'b0);
        n = 0;
        while (!have_cur && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!have_cur) fail_now("rsp_timeout");
        repeat (5) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_mul", 32'(rsp_data), 32'hFE01);
        end
        hold = 1'b0;
        wait_idle();

        send(3'd3, 8'h64, 8'h07, 1'b0);
        send(3'd4, 8'h64, 8'h07, 1'b0);
        send(3'd3, 8'h12, 8'h00, 1'b0);
        send(3'd2, 8'h12, 8'h00, 1'b0);
        send(3'd6, 8'h05, 8'h03, 1'b0);
        send(3'd7, 8'h05, 8'h03, 1'b0);
        send(3'd5, 8'h05, 8'h05, 1'b0);
        send(3'd1, 8'h03, 8'h05, 1'b0);
        send(3'd0, 8'h03, 8'h04, 1'b0);
        send(3'd0, 8'hAA, 8'h10, 1'b1);
        wait_idle();
        chk("acc_seq", 32'(rsp_data), ACC_EN ? 32'h0017 : 32'h00BA);

        // Reset while the operation is still settling
        send(3'd0, 8'h11, 8'h22, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        sb.delete();
        m_acc = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        send(3'd1, 8'h05, 8'h09, 1'b0);
        wait_idle();
        chk("post_rst_sub", 32'(rsp_data), 32'h00FC);

        for (int i = 0; i < 60; i++) begin
            logic [7:0] rb;
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            send(3'($urandom), 8'($urandom), rb, 1'($urandom));
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
